sdram_device_responder: RTL and testbench
=========================================

Name: sdram_device_responder

Overview:
- Cycle-accurate SDR SDRAM device responder: the memory end of the SDRAM pin interface driven by the team's SDRAM controller.
- Decodes CS/RAS/CAS/WE commands, tracks the mode register and per-bank open rows, stores write data, and returns read data after the programmed CAS latency.
- Flags protocol violations via sticky error outputs.
- Used in controller testbenches and FPGA loopback builds, so it must be synthesizable.

Parameters:
- SDRAM_ROW_W, 13, row address width.
- SDRAM_COL_W, 9, column address width.
- SDRAM_BANK_W, 2, bank address width (4 banks).
- SDRAM_DATA_W, 16, data bus width.
- MEM_AW, 12, log2 of backing storage words.
- T_RCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- sdram_cke_i  in  1  clock enable; commands are ignored while low.
- sdram_cs_i  in  1  chip select, active low.
- sdram_ras_i  in  1  row strobe, active low.
- sdram_cas_i  in  1  column strobe, active low.
- sdram_we_i  in  1  write enable, active low.
- sdram_dqm_i  in  2  byte masks; 1 means masked.
- sdram_addr_i  in  13  row, column, or mode value.
- sdram_ba_i  in  2  bank select.
- sdram_data_i  in  16  write data driven by the controller.
- sdram_data_o  out  16  read data.
- sdram_data_en_o  out  1  high while sdram_data_o carries valid data.
- mode_loaded_o  out  1  LOAD_MODE has been accepted.
- refresh_count_o  out  16  count of accepted REFRESH commands.
- error_o  out  1  sticky protocol error flag.
- error_code_o  out  3  code of the first error.

Behaviour:
- Command decode: cmd = {cs, ras, cas, we}.
  - NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, TERMINATE 0110, PRECHARGE 0010, REFRESH 0001, LOAD_MODE 0000.
  - cs=1 is deselect and is treated as NOP.
  - A command is sampled only when cke_i=1.
- Reset values: data_o=0, data_en_o=0, mode_loaded_o=0, refresh_count_o=0, error_o=0, error_code_o=0. All banks closed, read pipeline and write burst cleared. Storage contents are not reset.
- Reset asserted mid-burst aborts the burst; data_en_o is 0 on the next cycle.
- LOAD_MODE: capture addr[9:0] and set mode_loaded_o.
  - Burst length field [2:0]: 000 gives BL1, 001 gives BL2. Other values raise error code 5.
  - CAS latency field [6:4]: only 2 or 3 are legal. Other values raise error code 5.
  - LOAD_MODE with any bank open raises error code 4.
- ACTIVE: opens row addr on bank ba and loads that bank's tRCD counter with T_RCD-1.
  - ACTIVE on an already-open bank raises error code 1.
- READ/WRITE:
  - Bank closed raises error code 2.
  - tRCD counter nonzero raises error code 3.
  - Mode not loaded raises error code 4.
  - Any errored command is not executed.
- Storage index = low MEM_AW bits of {row, ba, col}. Column comes from addr[SDRAM_COL_W-1:0]. Beat n uses col with bit0 replaced by (col[0]^n), i.e. wrap within a 2-word boundary.
- WRITE:
  - Beat 0 is sampled in the WRITE cycle; beat 1 (if BL2) in the following cycle.
  - Each byte is written only if its dqm bit is 0. dqm is sampled per beat.
- READ: beat n appears on data_o with data_en_o=1 exactly CL+n cycles after the READ edge. Data_en_o=0 otherwise.
- Burst interruption:
  - A READ/WRITE/TERMINATE/PRECHARGE issued during a write burst ends it; beat 1 is not written.
  - A new READ issued during an in-flight read truncates the old burst to beats already launched; the new burst takes the pipeline.
- PRECHARGE: addr[10]=1 closes all banks; otherwise it closes bank ba. Closing an already-closed bank is legal.
- REFRESH: increment refresh_count_o, wrapping at 16 bits. Any bank open raises error code 6.
- Errors:
  - Only the first error is latched into error_code_o. error_o stays high until reset.
  - Simultaneous conditions resolve by lowest code.
  - Code 7 is reserved.

Decomposition:
- Package sdram_resp_pkg holds:
  - CMD_* 4-bit constants.
  - ERR_* 3-bit codes.
  - typedef bank_state_t {open, row, trcd_cnt}.
  - mode register field positions.
- Sub-module sdram_resp_rd_pipe: CAS-latency delay line, depth 3, carrying {valid, storage index}.
  - Flush input for truncation and reset.
  - Selectable tap for CL2/CL3.

Test Plan:
- Init: PRECHARGE all, REFRESH x2, LOAD_MODE 0x021 -> mode_loaded_o=1, refresh_count_o=2, error_o=0.
- ACTIVE bank1 row 0x12; wait 2 cycles; WRITE col 4 data 0xA5A5, 0x5A5A; READ col 4 -> data_en_o rises 2 cycles after READ, data 0xA5A5 then 0x5A5A.
- Write 0xFFFF then WRITE 0x1234 with dqm=2'b10 -> readback 0xFF34.
- READ bank 2 without ACTIVE -> error_o=1, error_code_o=2, no data_en_o.
- ACTIVE bank0, then READ the next cycle with T_RCD=2 -> error_code_o=3.
- REFRESH with bank 3 open -> error_code_o=6; then rst_i -> all outputs at reset values, banks closed.

Source files
------------

// File: rtl/sdram_resp_pkg.sv
// sdram_resp_pkg: shared commands, error codes, bank state and mode register fields
package sdram_resp_pkg;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_TERMINATE = 4'b0110;
    localparam logic [3:0] CMD_NOP       = 4'b0111;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_ACT_OPEN    = 3'd1;
    localparam logic [2:0] ERR_BANK_CLOSED = 3'd2;
    localparam logic [2:0] ERR_TRCD        = 3'd3;
    localparam logic [2:0] ERR_MODE        = 3'd4;
    localparam logic [2:0] ERR_MODE_FIELD  = 3'd5;
    localparam logic [2:0] ERR_REF_OPEN    = 3'd6;

    localparam int MODE_BL_LSB = 0;
    localparam int MODE_CL_LSB = 4;
    localparam logic [2:0] MODE_BL1 = 3'b000;
    localparam logic [2:0] MODE_BL2 = 3'b001;
    localparam logic [2:0] MODE_CL2 = 3'd2;
    localparam logic [2:0] MODE_CL3 = 3'd3;

    typedef struct packed {
        logic        open;
        logic [12:0] row;
        logic [2:0]  trcd_cnt;
    } bank_state_t;

    function automatic logic mode_legal(input logic [2:0] bl, input logic [2:0] cl);
        return (bl == MODE_BL1 || bl == MODE_BL2) && (cl == MODE_CL2 || cl == MODE_CL3);
    endfunction
endpackage

// File: rtl/sdram_resp_rd_pipe.sv
// sdram_resp_rd_pipe: CAS-latency delay line carrying {valid, storage index}
module sdram_resp_rd_pipe #(
    parameter int IDX_W = 12
) (
    input  logic             clk_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             cl3_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [2:0]       vld_q;
    logic [IDX_W-1:0] idx_q [3];

    // shift entries one stage per cycle; flush only drops the valid bits
    always_ff @(posedge clk_i) begin
        vld_q    <= flush_i ? 3'b000 : {vld_q[1:0], push_i};
        idx_q[0] <= idx_i;
        idx_q[1] <= idx_q[0];
        idx_q[2] <= idx_q[1];
    end

    assign valid_o = cl3_i ? vld_q[2] : vld_q[1];
    assign idx_o   = cl3_i ? idx_q[2] : idx_q[1];
endmodule

// File: rtl/sdram_device_responder.sv
// sdram_device_responder: cycle-accurate SDR SDRAM memory-side model
module sdram_device_responder
    import sdram_resp_pkg::*;
#(
    parameter int SDRAM_ROW_W  = 13,
    parameter int SDRAM_COL_W  = 9,
    parameter int SDRAM_BANK_W = 2,
    parameter int SDRAM_DATA_W = 16,
    parameter int MEM_AW       = 12,
    parameter int T_RCD        = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      sdram_cke_i,
    input  logic                      sdram_cs_i,
    input  logic                      sdram_ras_i,
    input  logic                      sdram_cas_i,
    input  logic                      sdram_we_i,
    input  logic [SDRAM_DATA_W/8-1:0] sdram_dqm_i,
    input  logic [SDRAM_ROW_W-1:0]    sdram_addr_i,
    input  logic [SDRAM_BANK_W-1:0]   sdram_ba_i,
    input  logic [SDRAM_DATA_W-1:0]   sdram_data_i,
    output logic [SDRAM_DATA_W-1:0]   sdram_data_o,
    output logic                      sdram_data_en_o,
    output logic                      mode_loaded_o,
    output logic [15:0]               refresh_count_o,
    output logic                      error_o,
    output logic [2:0]                error_code_o
);
    localparam int NB = 1 << SDRAM_BANK_W;

    logic [SDRAM_DATA_W-1:0] mem [1 << MEM_AW];
    bank_state_t             bank_q [NB];
    bank_state_t             sel;
    logic [3:0]              cmd;
    logic [2:0]              err_code;
    logic [MEM_AW-1:0]       idx0, idx1, wr_idx_q, rd_idx_q, wr_idx, rd_idx;
    logic                    any_open, is_rw, ok, do_rd, do_wr, wr_end, wr_en;
    logic                    bl2_q, cl3_q, wr_pend_q, rd_pend_q, rd_valid;

    function automatic logic [MEM_AW-1:0] mem_idx(input logic [SDRAM_ROW_W-1:0] r,
                                                  input logic [SDRAM_BANK_W-1:0] b,
                                                  input logic [SDRAM_COL_W-1:0] c);
        return MEM_AW'({r, b, c});
    endfunction

    assign cmd    = (sdram_cke_i && !sdram_cs_i) ? {sdram_cs_i, sdram_ras_i, sdram_cas_i, sdram_we_i} : CMD_NOP;
    assign sel    = bank_q[sdram_ba_i];
    assign is_rw  = cmd == CMD_READ || cmd == CMD_WRITE;
    assign idx0   = mem_idx(sel.row[SDRAM_ROW_W-1:0], sdram_ba_i, sdram_addr_i[SDRAM_COL_W-1:0]);
    assign idx1   = idx0 ^ MEM_AW'(1);

    // any open bank blocks LOAD_MODE and REFRESH
    always_comb begin
        any_open = 1'b0;
        for (int b = 0; b < NB; b++) any_open = any_open | bank_q[b].open;
    end

    // each command can only raise its own codes, so a priority chain gives lowest-code-wins
    assign err_code = (cmd == CMD_ACTIVE && sel.open) ? ERR_ACT_OPEN :
                      (is_rw && !sel.open) ? ERR_BANK_CLOSED :
                      (is_rw && sel.trcd_cnt != 3'd0) ? ERR_TRCD :
                      ((is_rw && !mode_loaded_o) || (cmd == CMD_LOAD_MODE && any_open)) ? ERR_MODE :
                      (cmd == CMD_LOAD_MODE && !mode_legal(sdram_addr_i[MODE_BL_LSB+:3], sdram_addr_i[MODE_CL_LSB+:3])) ? ERR_MODE_FIELD :
                      (cmd == CMD_REFRESH && any_open) ? ERR_REF_OPEN : ERR_NONE;

    assign ok     = err_code == ERR_NONE && !rst_i;
    assign do_rd  = cmd == CMD_READ && ok;
    assign do_wr  = cmd == CMD_WRITE && ok;
    assign wr_end = is_rw || cmd == CMD_TERMINATE || cmd == CMD_PRECHARGE;
    assign wr_en  = !rst_i && (do_wr || (wr_pend_q && !wr_end));
    assign wr_idx = do_wr ? idx0 : wr_idx_q;

    // byte-masked storage write, one beat per cycle
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < SDRAM_DATA_W / 8; b++)
            if (wr_en && !sdram_dqm_i[b]) mem[wr_idx][b*8+:8] <= sdram_data_i[b*8+:8];
    end

    // per-bank open row and tRCD countdown
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (rst_i) begin
                bank_q[b] <= '0;
            end else begin
                if (bank_q[b].trcd_cnt != 3'd0) bank_q[b].trcd_cnt <= bank_q[b].trcd_cnt - 3'd1;
                if (cmd == CMD_ACTIVE && ok && sdram_ba_i == SDRAM_BANK_W'(b))
                    bank_q[b] <= '{open: 1'b1, row: 13'(sdram_addr_i), trcd_cnt: 3'(T_RCD - 1)};
                if (cmd == CMD_PRECHARGE && (sdram_addr_i[10] || sdram_ba_i == SDRAM_BANK_W'(b)))
                    bank_q[b].open <= 1'b0;
            end
        end
    end

    sdram_resp_rd_pipe #(.IDX_W(MEM_AW)) u_rd_pipe (
        .clk_i   (clk_i),
        .flush_i (rst_i),
        .push_i  (do_rd || rd_pend_q),
        .idx_i   (do_rd ? idx0 : rd_idx_q),
        .cl3_i   (cl3_q),
        .valid_o (rd_valid),
        .idx_o   (rd_idx)
    );

    // mode, refresh count, burst continuation, sticky error and read data
    always_ff @(posedge clk_i) begin
        wr_idx_q <= idx1;
        rd_idx_q <= idx1;
        if (rst_i) begin
            sdram_data_o    <= '0;
            sdram_data_en_o <= 1'b0;
            mode_loaded_o   <= 1'b0;
            refresh_count_o <= '0;
            error_o         <= 1'b0;
            error_code_o    <= ERR_NONE;
            bl2_q           <= 1'b0;
            cl3_q           <= 1'b0;
            wr_pend_q       <= 1'b0;
            rd_pend_q       <= 1'b0;
        end else begin
            wr_pend_q       <= do_wr && bl2_q;
            rd_pend_q       <= do_rd && bl2_q;
            sdram_data_en_o <= rd_valid;
            sdram_data_o    <= rd_valid ? mem[rd_idx] : '0;
            if (cmd == CMD_LOAD_MODE && ok) begin
                mode_loaded_o <= 1'b1;
                bl2_q         <= sdram_addr_i[MODE_BL_LSB+:3] == MODE_BL2;
                cl3_q         <= sdram_addr_i[MODE_CL_LSB+:3] == MODE_CL3;
            end
            if (cmd == CMD_REFRESH && ok) refresh_count_o <= refresh_count_o + 16'd1;
            if (err_code != ERR_NONE && !error_o) begin
                error_o      <= 1'b1;
                error_code_o <= err_code;
            end
        end
    end
endmodule

// File: tb/tb_sdram_device_responder.sv
// tb_sdram_device_responder: directed scoreboard bench for the SDRAM responder
module tb_sdram_device_responder;
    import sdram_resp_pkg::*;

    localparam int CL = 2;

    logic        clk = 1'b0, rst = 1'b1, cke = 1'b1;
    logic        cs = 1'b0, ras = 1'b1, cas = 1'b1, we = 1'b1;
    logic [1:0]  dqm = '0, ba = '0;
    logic [12:0] addr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout, refcnt;
    logic        den, mload, err;
    logic [2:0]  ecode;

    typedef struct { int c; logic [15:0] d; } exp_t;
    exp_t q[$];
    int   cyc = 0, checks = 0, errors = 0;

    sdram_device_responder dut (
        .clk_i(clk), .rst_i(rst), .sdram_cke_i(cke), .sdram_cs_i(cs), .sdram_ras_i(ras),
        .sdram_cas_i(cas), .sdram_we_i(we), .sdram_dqm_i(dqm), .sdram_addr_i(addr),
        .sdram_ba_i(ba), .sdram_data_i(din), .sdram_data_o(dout), .sdram_data_en_o(den),
        .mode_loaded_o(mload), .refresh_count_o(refcnt), .error_o(err), .error_code_o(ecode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // read-data scoreboard: beats are due at a known edge count, silence is required otherwise
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].c == cyc) begin
            chk("rd_en", {15'b0, den}, 16'd1);
            chk("rd_data", dout, q[0].d);
            void'(q.pop_front());
        end else begin
            chk("idle_en", {15'b0, den}, 16'd0);
        end
    end

    task automatic drive(input logic [3:0] c, input logic [1:0] b = '0, input logic [12:0] a = '0,
                         input logic [15:0] d = '0, input logic [1:0] m = '0);
        @(negedge clk);
        {cs, ras, cas, we} = c;
        ba = b; addr = a; din = d; dqm = m;
    endtask

    task automatic nops(input int n);
        repeat (n) drive(CMD_NOP);
    endtask

    task automatic wr(input logic [1:0] b, input logic [12:0] col, input logic [15:0] d0,
                      input logic [1:0] m0, input logic [15:0] d1, input logic [1:0] m1);
        drive(CMD_WRITE, b, col, d0, m0);
        drive(CMD_NOP, '0, '0, d1, m1);
    endtask

    // beats not yet launched into the latency line are dropped by a newer READ
    task automatic rd(input logic [1:0] b, input logic [12:0] col, input logic [15:0] d0, input logic [15:0] d1);
        drive(CMD_READ, b, col);
        while (q.size() > 0 && q[q.size()-1].c >= cyc + 1 + CL) void'(q.pop_back());
        q.push_back('{cyc + 1 + CL, d0});
        q.push_back('{cyc + 2 + CL, d1});
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        {cs, ras, cas, we} = CMD_NOP;
        while (q.size() > 0 && q[q.size()-1].c > cyc) void'(q.pop_back());
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic status(input string tag, input logic e, input logic [2:0] code);
        chk({tag, "_err"}, {15'b0, err}, {15'b0, e});
        chk({tag, "_code"}, {13'b0, ecode}, {13'b0, code});
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_data"}, dout, 16'h0);
        chk({tag, "_en"}, {15'b0, den}, 16'd0);
        chk({tag, "_mode"}, {15'b0, mload}, 16'd0);
        chk({tag, "_refcnt"}, refcnt, 16'd0);
        status(tag, 1'b0, 3'd0);
    endtask

    initial begin
        do_reset(3);
        reset_vals("rst0");

        drive(CMD_PRECHARGE, 2'd0, 13'h400);
        drive(CMD_REFRESH);
        drive(CMD_REFRESH);
        drive(CMD_LOAD_MODE, 2'd0, 13'h021);
        nops(1);
        chk("init_mode", {15'b0, mload}, 16'd1);
        chk("init_refcnt", refcnt, 16'd2);
        status("init", 1'b0, 3'd0);

        drive(CMD_ACTIVE, 2'd1, 13'h12);
        nops(1);
        wr(2'd1, 13'd4, 16'hA5A5, 2'b00, 16'h5A5A, 2'b00);
        rd(2'd1, 13'd4, 16'hA5A5, 16'h5A5A);
        nops(4);
        wr(2'd1, 13'd8, 16'hFFFF, 2'b00, 16'hFFFF, 2'b00);
        wr(2'd1, 13'd8, 16'h1234, 2'b10, 16'h0000, 2'b11);
        rd(2'd1, 13'd8, 16'hFF34, 16'hFFFF);
        nops(4);
        wr(2'd1, 13'd16, 16'h0101, 2'b00, 16'h0202, 2'b00);
        drive(CMD_WRITE, 2'd1, 13'd16, 16'h1111);
        rd(2'd1, 13'd16, 16'h1111, 16'h0202);
        nops(4);
        rd(2'd1, 13'd4, 16'hA5A5, 16'h5A5A);
        rd(2'd1, 13'd8, 16'hFF34, 16'hFFFF);
        nops(4);
        rd(2'd1, 13'd5, 16'h5A5A, 16'hA5A5);
        nops(4);
        status("data", 1'b0, 3'd0);

        rd(2'd1, 13'd4, 16'hA5A5, 16'h5A5A);
        do_reset(2);
        reset_vals("rst_mid");

        drive(CMD_READ, 2'd2, 13'd0);
        nops(4);
        status("rd_closed", 1'b1, 3'd2);

        do_reset(2);
        drive(CMD_LOAD_MODE, 2'd0, 13'h021);
        drive(CMD_ACTIVE, 2'd0, 13'd1);
        drive(CMD_READ, 2'd0, 13'd0);
        nops(4);
        status("trcd", 1'b1, 3'd3);

        do_reset(2);
        drive(CMD_ACTIVE, 2'd3, 13'd5);
        drive(CMD_REFRESH);
        nops(1);
        status("ref_open", 1'b1, 3'd6);
        do_reset(2);
        reset_vals("rst_end");
        drive(CMD_ACTIVE, 2'd3, 13'd5);
        nops(1);
        status("closed_after_rst", 1'b0, 3'd0);
        drive(CMD_ACTIVE, 2'd3, 13'd6);
        nops(1);
        status("act_open", 1'b1, 3'd1);

        do_reset(2);
        drive(CMD_LOAD_MODE, 2'd0, 13'h041);
        nops(1);
        status("bad_cl", 1'b1, 3'd5);
        do_reset(2);
        drive(CMD_ACTIVE, 2'd2, 13'd1);
        drive(CMD_LOAD_MODE, 2'd0, 13'h045);
        nops(1);
        status("lm_open", 1'b1, 3'd4);

        nops(6);
        chk("drain", 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
